// File: rtl/r_response_memory_if.sv
// rtl/r_response_memory_if.sv - R-channel beat bundle shared by the store and release ports
//
// Purpose: carries one R beat (id/data/resp/last) with a valid/ready handshake.
// Ports (signals):
//   valid  sender -> receiver  beat present
//   ready  receiver -> sender  beat can be taken this cycle
//   id     sender -> receiver  [ID_WIDTH]
//   data   sender -> receiver  [DATA_WIDTH]
//   resp   sender -> receiver  [RESP_WIDTH]
//   last   sender -> receiver  final beat of a burst
interface r_if #(
  parameter int ID_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;

  modport sender   (output valid, id, data, resp, last, input  ready);
  modport receiver (input  valid, id, data, resp, last, output ready);

  // Aliases for code that thinks in master/slave terms.
  modport master   (output valid, id, data, resp, last, input  ready);
  modport slave    (input  valid, id, data, resp, last, output ready);
endinterface

// File: rtl/r_response_memory.sv
// rtl/r_response_memory.sv - per-uid R-beat FIFO store with zero-latency release by uid
//
// Purpose: buffers R beats into one small FIFO per uid ({row,col} taken from the
// low id bits). A consumer selects a uid on rm_release_uid and pops its oldest
// beat through r_release.
// Ports:
//   clk             in   clock, all state on rising edge
//   rst             in   asynchronous active-high reset
//   r_store         r_if.receiver  incoming beats; ready = selected uid not full
//   rm_release_uid  in   [ID_WIDTH] uid presented on r_release
//   r_release       r_if.sender    oldest beat of rm_release_uid; ready pops it
//   occupancy       out  total beats held across all uids
module r_response_memory #(
  parameter int ID_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int NUM_ROWS   = 16,
  parameter int NUM_COLS   = 16,
  parameter int MAX_LEN    = 8,
  localparam int OCC_W     = $clog2(NUM_ROWS*NUM_COLS*MAX_LEN+1)
) (
  input  logic                clk,
  input  logic                rst,
  r_if.receiver               r_store,
  input  logic [ID_WIDTH-1:0] rm_release_uid,
  r_if.sender                 r_release,
  output logic [OCC_W-1:0]    occupancy
);

  localparam int ROW_W  = $clog2(NUM_ROWS);
  localparam int COL_W  = $clog2(NUM_COLS);
  localparam int UID_W  = ROW_W + COL_W;
  localparam int SLOTS  = NUM_ROWS * NUM_COLS;
  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  localparam int PTR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int BEAT_W = DATA_WIDTH + RESP_WIDTH + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_LEN);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_LEN - 1);

  // Per-uid bookkeeping; cleared by reset.
  logic [PTR_W-1:0] wr_ptr [SLOTS];
  logic [PTR_W-1:0] rd_ptr [SLOTS];
  logic [CNT_W-1:0] cnt    [SLOTS];

  // Beat payload storage; never reset, only read where cnt says it is live.
  logic [BEAT_W-1:0] beat_mem [SLOTS][MAX_LEN];

  logic [UID_W-1:0]  st_uid;
  logic [UID_W-1:0]  rl_uid;
  logic              st_hs;
  logic              rl_hs;
  logic              same_uid;
  logic [BEAT_W-1:0] rd_beat;

  // Explicit wrap so non-power-of-2 depths never index past MAX_LEN-1.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // High id bits are ignored; only {row,col} selects the slot.
  assign st_uid = r_store.id[UID_W-1:0];
  assign rl_uid = rm_release_uid[UID_W-1:0];

  // Ready depends on stored count only, so a same-cycle release on a full
  // uid cannot open the door until the next cycle.
  assign r_store.ready = (cnt[st_uid] < FULL_CNT);
  assign st_hs         = r_store.valid & r_store.ready;

  assign r_release.valid = (cnt[rl_uid] != '0);
  assign rl_hs           = r_release.valid & r_release.ready;
  assign same_uid        = (st_uid == rl_uid);

  // Read straight from registered storage: a beat written this cycle only
  // appears once its count update has landed, i.e. next cycle.
  assign rd_beat = beat_mem[rl_uid][rd_ptr[rl_uid]];

  always_comb begin
    r_release.id   = rm_release_uid;
    r_release.data = '0;
    r_release.resp = '0;
    r_release.last = 1'b0;
    if (r_release.valid) begin
      r_release.data = rd_beat[BEAT_W-1 -: DATA_WIDTH];
      r_release.resp = rd_beat[RESP_WIDTH:1];
      r_release.last = rd_beat[0];
    end
  end

  always_ff @(posedge clk) begin
    if (st_hs) begin
      beat_mem[st_uid][wr_ptr[st_uid]] <= {r_store.data, r_store.resp, r_store.last};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      if (st_hs) begin
        wr_ptr[st_uid] <= ptr_next(wr_ptr[st_uid]);
      end
      if (rl_hs) begin
        rd_ptr[rl_uid] <= ptr_next(rd_ptr[rl_uid]);
      end
      // Store and release on the same uid cancel out in the count.
      if (st_hs && !(rl_hs && same_uid)) begin
        cnt[st_uid] <= cnt[st_uid] + 1'b1;
      end
      if (rl_hs && !(st_hs && same_uid)) begin
        cnt[rl_uid] <= cnt[rl_uid] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      case ({st_hs, rl_hs})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_r_response_memory.sv
// tb/tb_r_response_memory.sv - bench for r_response_memory
module tb_r_response_memory;

  localparam int OCC_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       rm_release_uid;
  logic [OCC_W-1:0]  occupancy;

  r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) st_bus ();
  r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) rl_bus ();

  r_response_memory dut (
    .clk            (clk),
    .rst            (rst),
    .r_store        (st_bus),
    .rm_release_uid (rm_release_uid),
    .r_release      (rl_bus),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue of {data,resp,last} per uid, plus a beat total.
  logic [66:0] mq [256][$];
  int          occ_m = 0;

  logic        obs_srdy;
  logic        obs_rvld;
  logic [63:0] obs_rdata;
  logic        obs_rlast;
  logic [31:0] obs_rid;
  int          obs_occ;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle: drive after the falling edge, check combinational outputs
  // against the model, then let the rising edge commit and update the model.
  task automatic step(input logic sv, input logic [31:0] sid, input logic [63:0] sd,
                      input logic sl, input logic [31:0] rid, input logic rr);
    logic [7:0]  su;
    logic [7:0]  ru;
    logic        e_rdy;
    logic        e_vld;
    logic [66:0] e_beat;
    logic        s_hs;
    logic        r_hs;
    @(negedge clk);
    st_bus.valid   = sv;
    st_bus.id      = sid;
    st_bus.data    = sd;
    st_bus.resp    = sd[1:0];
    st_bus.last    = sl;
    rm_release_uid = rid;
    rl_bus.ready   = rr;
    #1;
    su     = sid[7:0];
    ru     = rid[7:0];
    e_rdy  = (mq[su].size() < 8);
    e_vld  = (mq[ru].size() != 0);
    e_beat = e_vld ? mq[ru][0] : '0;
    obs_srdy  = st_bus.ready;
    obs_rvld  = rl_bus.valid;
    obs_rdata = rl_bus.data;
    obs_rlast = rl_bus.last;
    obs_rid   = rl_bus.id;
    obs_occ   = int'(occupancy);
    chk("st_ready", st_bus.ready, e_rdy);
    chk("rl_valid", rl_bus.valid, e_vld);
    chk("rl_data",  rl_bus.data,  e_beat[66:3]);
    chk("rl_resp",  rl_bus.resp,  e_beat[2:1]);
    chk("rl_last",  rl_bus.last,  e_beat[0]);
    chk("rl_id",    rl_bus.id,    rid);
    chk("occupancy", occupancy,   occ_m);
    s_hs = sv && e_rdy;
    r_hs = rr && e_vld;
    @(posedge clk);
    if (r_hs) void'(mq[ru].pop_front());
    if (s_hs) mq[su].push_back({sd, sd[1:0], sl});
    occ_m = occ_m + int'(s_hs) - int'(r_hs);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mq[i].delete();
    occ_m = 0;
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] sid;
    logic [63:0] sd;
    logic        sl;
    logic [31:0] rid;
    logic        rr;
    logic        e_srdy;
    logic        e_rvld;
    logic [63:0] e_rdata;
    logic        e_rlast;
    int          e_occ;
  } vec_t;

  vec_t vt [15];

  initial begin
    logic [7:0]  uset [4];
    logic [31:0] r32;
    logic [31:0] sid;
    logic [31:0] rid;

    vt[0]  = '{1'b1, 32'h12,       64'hA, 1'b0, 32'h12,       1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 0};
    vt[1]  = '{1'b1, 32'hABCD0012, 64'hB, 1'b0, 32'h12,       1'b0, 1'b1, 1'b1, 64'hA, 1'b0, 1};
    vt[2]  = '{1'b1, 32'h12,       64'hC, 1'b1, 32'h12,       1'b0, 1'b1, 1'b1, 64'hA, 1'b0, 2};
    vt[3]  = '{1'b0, 32'h0,        64'h0, 1'b0, 32'h12,       1'b1, 1'b1, 1'b1, 64'hA, 1'b0, 3};
    vt[4]  = '{1'b0, 32'h0,        64'h0, 1'b0, 32'hFFFFFF12, 1'b1, 1'b1, 1'b1, 64'hB, 1'b0, 2};
    vt[5]  = '{1'b0, 32'h0,        64'h0, 1'b0, 32'h12,       1'b1, 1'b1, 1'b1, 64'hC, 1'b1, 1};
    vt[6]  = '{1'b0, 32'h0,        64'h0, 1'b0, 32'h12,       1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 0};
    vt[7]  = '{1'b1, 32'h03,       64'hD, 1'b1, 32'h03,       1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 0};
    vt[8]  = '{1'b0, 32'h0,        64'h0, 1'b0, 32'h03,       1'b0, 1'b1, 1'b1, 64'hD, 1'b1, 1};
    vt[9]  = '{1'b0, 32'h0,        64'h0, 1'b0, 32'h03,       1'b1, 1'b1, 1'b1, 64'hD, 1'b1, 1};
    vt[10] = '{1'b1, 32'h07,       64'hE, 1'b0, 32'h07,       1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 0};
    vt[11] = '{1'b1, 32'h07,       64'hF, 1'b1, 32'h07,       1'b1, 1'b1, 1'b1, 64'hE, 1'b0, 1};
    vt[12] = '{1'b0, 32'h0,        64'h0, 1'b0, 32'h07,       1'b0, 1'b1, 1'b1, 64'hF, 1'b1, 1};
    vt[13] = '{1'b0, 32'h0,        64'h0, 1'b0, 32'h07,       1'b1, 1'b1, 1'b1, 64'hF, 1'b1, 1};
    vt[14] = '{1'b0, 32'h0,        64'h0, 1'b0, 32'h07,       1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 0};

    st_bus.valid = 1'b0; st_bus.id = '0; st_bus.data = '0; st_bus.resp = '0; st_bus.last = 1'b0;
    rl_bus.ready = 1'b0; rm_release_uid = 32'h12;
    model_clear();

    // Reset state
    #12;
    chk("rst_ready", st_bus.ready, 1'b1);
    chk("rst_valid", rl_bus.valid, 1'b0);
    chk("rst_occ",   occupancy,    0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: ordered release, no bypass, simultaneous store/release
    for (int i = 0; i < 15; i++) begin
      step(vt[i].sv, vt[i].sid, vt[i].sd, vt[i].sl, vt[i].rid, vt[i].rr);
      chk($sformatf("tbl%0d_srdy", i),  obs_srdy,  vt[i].e_srdy);
      chk($sformatf("tbl%0d_rvld", i),  obs_rvld,  vt[i].e_rvld);
      chk($sformatf("tbl%0d_rdata", i), obs_rdata, vt[i].e_rdata);
      chk($sformatf("tbl%0d_rlast", i), obs_rlast, vt[i].e_rlast);
      chk($sformatf("tbl%0d_rid", i),   obs_rid,   vt[i].rid);
      chk($sformatf("tbl%0d_occ", i),   obs_occ,   vt[i].e_occ);
    end

    // Fill uid 0x05, stall the 9th, release one, then drain across the wrap
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h05, 64'h100 + 64'(i), 1'b0, 32'h05, 1'b0);
      chk("full_fill_rdy", obs_srdy, 1'b1);
    end
    step(1'b1, 32'h05, 64'h108, 1'b1, 32'h05, 1'b0);
    chk("full_stall_rdy", obs_srdy, 1'b0);
    chk("full_occ", obs_occ, 8);
    step(1'b1, 32'h05, 64'h108, 1'b1, 32'h05, 1'b1);
    chk("full_same_cycle_rdy", obs_srdy, 1'b0);
    chk("full_pop_data", obs_rdata, 64'h100);
    step(1'b1, 32'h05, 64'h108, 1'b1, 32'h05, 1'b0);
    chk("full_reopen_rdy", obs_srdy, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 32'h0, 64'h0, 1'b0, 32'h05, 1'b1);
      chk("wrap_order", obs_rdata, 64'h100 + 64'(j));
    end
    step(1'b0, 32'h0, 64'h0, 1'b0, 32'h05, 1'b0);
    chk("wrap_empty", obs_rvld, 1'b0);

    // Interleaved uids 0x01 / 0x10
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h01, 64'h200 + 64'(i), 1'b0, 32'h10, 1'b0);
      step(1'b1, 32'h10, 64'h300 + 64'(i), 1'b0, 32'h10, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 64'h0, 1'b0, 32'h10, 1'b1);
      chk("ilv_uid10", obs_rdata, 64'h300 + 64'(i));
    end
    step(1'b0, 32'h0, 64'h0, 1'b0, 32'h10, 1'b0);
    chk("ilv_uid10_empty", obs_rvld, 1'b0);
    chk("ilv_occ", obs_occ, 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 64'h0, 1'b0, 32'h01, 1'b1);
      chk("ilv_uid01", obs_rdata, 64'h200 + 64'(i));
    end

    // Asynchronous reset with 5 beats across 3 uids
    step(1'b1, 32'h20, 64'h401, 1'b0, 32'h20, 1'b0);
    step(1'b1, 32'h20, 64'h402, 1'b0, 32'h20, 1'b0);
    step(1'b1, 32'h21, 64'h403, 1'b0, 32'h20, 1'b0);
    step(1'b1, 32'h21, 64'h404, 1'b0, 32'h20, 1'b0);
    step(1'b1, 32'h22, 64'h405, 1'b0, 32'h20, 1'b0);
    @(negedge clk);
    st_bus.valid = 1'b1; st_bus.id = 32'h21; st_bus.data = 64'h4FF;
    rm_release_uid = 32'h20; rl_bus.ready = 1'b1;
    #1;
    chk("pre_rst_occ", occupancy, 5);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_occ",   occupancy,    0);
    chk("arst_ready", st_bus.ready, 1'b1);
    for (int u = 32; u < 35; u++) begin
      rm_release_uid = 32'(u);
      #1;
      chk("arst_valid", rl_bus.valid, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("rst_edge_occ", occupancy, 0);
    chk("rst_edge_valid", rl_bus.valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    st_bus.valid = 1'b0; rl_bus.ready = 1'b0;
    model_clear();
    step(1'b1, 32'h20, 64'h999, 1'b1, 32'h20, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 32'h20, 1'b1);
    chk("post_rst_data", obs_rdata, 64'h999);
    chk("post_rst_last", obs_rlast, 1'b1);

    // Randomized traffic on a few uids, checked against the queue model
    uset[0] = 8'h00; uset[1] = 8'h0F; uset[2] = 8'hF0; uset[3] = 8'hFF;
    for (int n = 0; n < 3000; n++) begin
      r32 = $urandom;
      sid = (r32 & 32'hFFFFFF00) | 32'(uset[$urandom_range(0, 3)]);
      r32 = $urandom;
      rid = (r32 & 32'hFFFFFF00) | 32'(uset[$urandom_range(0, 3)]);
      step($urandom_range(0, 9) < 6, sid, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           rid, $urandom_range(0, 9) < 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
